// File: rtl/ysyx_22050058_ifu.sv
// ysyx_22050058_ifu -- instruction fetch unit.
//
// Owns the PC and fetches one instruction at a time over a req/gnt/rvalid
// instruction-memory port (at most one request outstanding). The fetched
// instruction is presented to the IF/ID register together with its pc and a
// static not-taken prediction (pc+4). Redirects from ctrl (flush_i[0]) replace
// the PC at any point; a response already in flight is marked to be dropped.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall_i[5:0]       ctrl stall vector, bit0 holds the PC stage
//   flush_i[5:0]       ctrl flush vector, bit0 redirects the PC stage
//   redirect_pc_i      redirect target, sampled while flush_i[0]=1
//   imem_req_o/addr_o  fetch request and its address (always the current pc)
//   imem_gnt_i         request accepted this cycle
//   imem_rvalid_i      response valid, imem_rdata_i carries the instruction
//   if_pc_o/if_dnpc_o  pc of the presented instruction and pc+4
//   if_inst_o          presented instruction, 0 when no instruction
//   if_valid_o         outputs carry a real instruction
//   stallreq_if_o      a fetch is pending
module ysyx_22050058_ifu #(
  parameter int                 ADDR_W     = 64,
  parameter int                 INST_W     = 32,
  parameter logic [ADDR_W-1:0]  RST_VECTOR = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic [5:0]        flush_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] if_dnpc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              stallreq_if_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [INST_W-1:0]   inst_buf_reg, inst_buf_next;
  // Set when the response currently in flight belongs to a redirected-away pc.
  logic                kill_reg, kill_next;

  logic                redirect;
  logic [ADDR_W-1:0]   redirect_target;
  logic [ADDR_W-1:0]   pc_plus4;

  assign redirect        = flush_i[0];
  // Instructions are word aligned; low target bits are dropped.
  assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  // Wraps modulo 2^ADDR_W by construction.
  assign pc_plus4        = pc_reg + ADDR_W'(4);

  // Only bit0 of the ctrl vectors concerns this stage.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{stall_i[5:1], flush_i[5:1]};

  // The request address is always the pc; during ADDR without a grant a
  // redirect may move it, which is allowed because nothing was accepted yet.
  assign imem_addr_o = pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RST_VECTOR;
      inst_buf_reg <= '0;
      kill_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inst_buf_reg <= inst_buf_next;
      kill_reg     <= kill_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inst_buf_next = inst_buf_reg;
    kill_next     = kill_reg;
    imem_req_o    = 1'b0;
    if_valid_o    = 1'b0;
    if_pc_o       = '0;
    if_dnpc_o     = '0;
    if_inst_o     = '0;
    stallreq_if_o = 1'b0;

    case (state_reg)
      IDLE: begin
        if (redirect) begin
          pc_next = redirect_target;
        end
        state_next = ADDR;
      end

      ADDR: begin
        imem_req_o    = 1'b1;
        stallreq_if_o = 1'b1;
        if (redirect) begin
          pc_next = redirect_target;
        end
        if (imem_gnt_i) begin
          state_next = DATA;
          // The granted request targets the old pc; its response must go.
          if (redirect) begin
            kill_next = 1'b1;
          end
        end
      end

      DATA: begin
        stallreq_if_o = 1'b1;
        if (redirect) begin
          pc_next = redirect_target;
          if (imem_rvalid_i) begin
            kill_next  = 1'b0;
            state_next = ADDR;
          end else begin
            kill_next = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (kill_reg) begin
            kill_next  = 1'b0;
            state_next = ADDR;
          end else begin
            inst_buf_next = imem_rdata_i;
            state_next    = DONE;
          end
        end
      end

      DONE: begin
        if_valid_o = 1'b1;
        if_pc_o    = pc_reg;
        if_dnpc_o  = pc_plus4;
        if_inst_o  = inst_buf_reg;
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = ADDR;
        end else if (!stall_i[0]) begin
          pc_next    = pc_plus4;
          state_next = ADDR;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A response can only belong to the single request accepted earlier.
  a_rvalid_only_in_data: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid_i |-> (state_reg == DATA)
  );

endmodule

// File: tb/tb_ysyx_22050058_ifu.sv
module tb_ysyx_22050058_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i, flush_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [63:0] if_pc_o, if_dnpc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o, stallreq_if_o;

  int checks = 0;
  int errors = 0;

  ysyx_22050058_ifu dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_pc_o(if_pc_o), .if_dnpc_o(if_dnpc_o), .if_inst_o(if_inst_o),
    .if_valid_o(if_valid_o), .stallreq_if_o(stallreq_if_o)
  );

  always #5 clk = ~clk;

  // Inputs are applied between edges; outputs are read 1 time unit after an edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction content the bench's memory holds at a given address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  // From ADDR: grant at once, answer one cycle later, expect the presentation.
  task automatic fetch_one(input string tag, input logic [63:0] a, input logic [31:0] d);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin errors++; $display("FAIL %s_req got req=%b addr=%h exp req=1 addr=%h", tag, imem_req_o, imem_addr_o, a); end
    checks++; if (stallreq_if_o !== 1'b1) begin errors++; $display("FAIL %s_stallreq_addr got %b exp 1", tag, stallreq_if_o); end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || stallreq_if_o !== 1'b1 || if_valid_o !== 1'b0) begin errors++; $display("FAIL %s_data got req=%b stallreq=%b valid=%b exp 0/1/0", tag, imem_req_o, stallreq_if_o, if_valid_o); end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = d;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== a || if_dnpc_o !== a + 64'd4 || if_inst_o !== d) begin errors++; $display("FAIL %s_present got v=%b pc=%h dnpc=%h inst=%h exp v=1 pc=%h dnpc=%h inst=%h", tag, if_valid_o, if_pc_o, if_dnpc_o, if_inst_o, a, a + 64'd4, d); end
    checks++; if (stallreq_if_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL %s_done_req got stallreq=%b req=%b exp 0/0", tag, stallreq_if_o, imem_req_o); end
    $display("fetch %s pc=%h inst=%h", tag, if_pc_o, if_inst_o);
  endtask

  task automatic test_reset();
    stall_i = '0; flush_i = '0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || stallreq_if_o !== 1'b0) begin errors++; $display("FAIL reset_ctl got req=%b valid=%b stallreq=%b exp 0", imem_req_o, if_valid_o, stallreq_if_o); end
    checks++; if (if_pc_o !== 64'h0 || if_dnpc_o !== 64'h0 || if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_data got pc=%h dnpc=%h inst=%h exp 0", if_pc_o, if_dnpc_o, if_inst_o); end
    checks++; if (imem_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL reset_addr got %h exp 80000000", imem_addr_o); end
    rst = 1'b0;
    tick();
    fetch_one("boot", 64'h8000_0000, 32'h0000_0413);
  endtask

  task automatic test_sequential();
    tick();
    fetch_one("seq1", 64'h8000_0004, 32'h0010_0093);
    tick();
    fetch_one("seq2", 64'h8000_0008, 32'h0020_0113);
  endtask

  task automatic test_stall_hold();
    stall_i = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 64'h8000_0008 || if_inst_o !== 32'h0020_0113 || imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got v=%b pc=%h inst=%h req=%b exp 1/80000008/00200113/0", i, if_valid_o, if_pc_o, if_inst_o, imem_req_o); end
    end
    stall_i = 6'b000000;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_000C || if_valid_o !== 1'b0) begin errors++; $display("FAIL stall_release got req=%b addr=%h v=%b exp 1/8000000c/0", imem_req_o, imem_addr_o, if_valid_o); end
    $display("stall released next addr=%h", imem_addr_o);
  endtask

  task automatic test_redirect_data();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    flush_i = 6'b000001;
    redirect_pc_i = 64'h8000_0103;
    tick();
    flush_i = 6'b0;
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0 || stallreq_if_o !== 1'b1 || imem_addr_o !== 64'h8000_0100) begin errors++; $display("FAIL redir_wait got v=%b req=%b stallreq=%b addr=%h exp 0/0/1/80000100", if_valid_o, imem_req_o, stallreq_if_o, imem_addr_o); end
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0 || imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0100) begin errors++; $display("FAIL redir_drop got v=%b inst=%h req=%b addr=%h exp 0/0/1/80000100", if_valid_o, if_inst_o, imem_req_o, imem_addr_o); end
    fetch_one("redir", 64'h8000_0100, 32'h0030_0193);
  endtask

  task automatic test_gnt_hold_redirect();
    logic [63:0] exp_a;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        flush_i = 6'b000001;
        redirect_pc_i = 64'h8000_0200;
      end
      tick();
      flush_i = 6'b0;
      exp_a = (i >= 1) ? 64'h8000_0200 : 64'h8000_0104;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_a) begin errors++; $display("FAIL gnt_hold%0d got req=%b addr=%h exp 1/%h", i, imem_req_o, imem_addr_o, exp_a); end
    end
    fetch_one("gnthold", 64'h8000_0200, 32'h0040_0213);
  endtask

  task automatic test_reset_mid_data();
    tick();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || stallreq_if_o !== 1'b0 || if_pc_o !== 64'h0 || if_inst_o !== 32'h0 || imem_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL midrst got req=%b v=%b stallreq=%b pc=%h inst=%h addr=%h exp 0/0/0/0/0/80000000", imem_req_o, if_valid_o, stallreq_if_o, if_pc_o, if_inst_o, imem_addr_o); end
    tick();
    fetch_one("midrst", 64'h8000_0000, 32'h0050_0293);
  endtask

  task automatic test_wrap();
    flush_i = 6'b000001;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    flush_i = 6'b0;
    fetch_one("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313);
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0) begin errors++; $display("FAIL wrap_addr got req=%b addr=%h exp 1/0", imem_req_o, imem_addr_o); end
    $display("wrap next addr=%h", imem_addr_o);
  endtask

  // Random traffic checked against a transaction-level expectation: every
  // presented instruction must be the memory word at the pc the program
  // order implies (sequential +4 steps, replaced by the latest redirect).
  task automatic test_random();
    logic [63:0] exp_pc, mem_addr, tgt;
    bit          mem_busy, do_stall, do_flush;
    int          mem_cnt, presented;
    rst = 1'b1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; flush_i = '0; stall_i = '0;
    tick();
    rst = 1'b0;
    exp_pc = 64'h8000_0000;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; presented = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (if_valid_o) begin
        checks++; if (if_pc_o !== exp_pc || if_dnpc_o !== exp_pc + 64'd4 || if_inst_o !== mem_word(exp_pc)) begin errors++; $display("FAIL rand_present cyc%0d got pc=%h dnpc=%h inst=%h exp pc=%h dnpc=%h inst=%h", cyc, if_pc_o, if_dnpc_o, if_inst_o, exp_pc, exp_pc + 64'd4, mem_word(exp_pc)); end
      end else begin
        checks++; if (if_pc_o !== 64'h0 || if_dnpc_o !== 64'h0 || if_inst_o !== 32'h0) begin errors++; $display("FAIL rand_bubble cyc%0d got pc=%h dnpc=%h inst=%h exp 0", cyc, if_pc_o, if_dnpc_o, if_inst_o); end
      end
      // memory: at most one transaction, answered 1..3 cycles after grant
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(mem_addr);
          mem_busy = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      imem_gnt_i = 1'b0;
      if (imem_req_o && !mem_busy && ($urandom_range(0, 1) == 1)) begin
        imem_gnt_i = 1'b1;
        mem_busy = 1'b1;
        mem_addr = imem_addr_o;
        mem_cnt = $urandom_range(0, 2);
      end
      do_stall = ($urandom_range(0, 2) == 0);
      do_flush = ($urandom_range(0, 9) == 0);
      tgt = {$urandom, $urandom};
      stall_i = {6'($urandom) & 6'b111110} | {5'b0, do_stall};
      flush_i = {6'($urandom) & 6'b111110} | {5'b0, do_flush};
      redirect_pc_i = tgt;
      if (do_flush) begin
        exp_pc = {tgt[63:2], 2'b00};
      end else if (if_valid_o && !do_stall) begin
        exp_pc = exp_pc + 64'd4;
        presented++;
        $display("rand cyc%0d presented pc=%h inst=%h", cyc, if_pc_o, if_inst_o);
      end
      tick();
    end
    stall_i = '0; flush_i = '0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    checks++; if (presented < 10) begin errors++; $display("FAIL rand_progress got %0d presentations exp >= 10", presented); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_data();
    test_gnt_hold_redirect();
    test_reset_mid_data();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050058_ifu.md
Name: ysyx_22050058_ifu

Overview:
Instruction fetch unit. It owns the PC and fetches instructions over a req/gnt/rvalid instruction-memory port, one request outstanding at a time. It presents pc, predicted next pc and the instruction to the IF/ID pipeline register, and obeys the ctrl block's stall[5:0]/flush[5:0] vectors. It raises a stall request while a fetch is pending and accepts redirects (branch, jump or trap target) from ctrl.

Parameters:
ADDR_W, 64, PC/address width
INST_W, 32, instruction width
RST_VECTOR, 64'h8000_0000, PC after reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_i  in  6  ctrl stall vector; bit0 = PC stage
flush_i  in  6  ctrl flush vector; bit0 = PC stage
redirect_pc_i  in  ADDR_W  new fetch target, sampled when flush_i[0]=1
imem_req_o  out  1  request valid
imem_addr_o  out  ADDR_W  request address (= pc)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (at least 1 cycle after gnt)
imem_rdata_i  in  INST_W  response instruction
if_pc_o  out  ADDR_W  pc of presented instruction
if_dnpc_o  out  ADDR_W  pc+4 (static not-taken prediction)
if_inst_o  out  INST_W  instruction; 0 = bubble
if_valid_o  out  1  outputs carry a real instruction
stallreq_if_o  out  1  fetch pending, to ctrl

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pc=RST_VECTOR, inst_buf=0, kill=0. All outputs are 0, except imem_addr_o=RST_VECTOR.
- The memory side shares rst and drops outstanding transactions, so no response follows reset.
- States:
  - IDLE: always goes to ADDR next cycle.
  - ADDR: imem_req_o=1, imem_addr_o=pc. On imem_gnt_i go to DATA; otherwise hold req and addr stable.
  - DATA: wait for imem_rvalid_i. On rvalid with kill=0: inst_buf<=imem_rdata_i, go to DONE. On rvalid with kill=1: discard data, clear kill, go to ADDR.
  - DONE: if_valid_o=1, if_pc_o=pc, if_dnpc_o=pc+4, if_inst_o=inst_buf. If stall_i[0]=0: pc<=pc+4, go to ADDR. If stall_i[0]=1: hold state and outputs.
- Outside DONE: if_valid_o=0, if_pc_o=0, if_dnpc_o=0, if_inst_o=0 (bubble). stallreq_if_o=1 in ADDR and DATA, 0 in IDLE and DONE.
- Address arithmetic: pc+4 is modulo 2^ADDR_W and wraps with no error. Redirect target bits [1:0] are forced to 0.
- Redirect (flush_i[0]=1) has priority over stall_i and normal advance:
  - IDLE, DONE: pc<=target, go to ADDR.
  - ADDR with gnt=0: pc<=target, stay in ADDR. The address changes next cycle, which is legal because no grant was given.
  - ADDR with gnt=1: pc<=target, kill<=1, go to DATA.
  - DATA with rvalid=0: pc<=target, kill<=1.
  - DATA with rvalid=1: data discarded, pc<=target, kill<=0, go to ADDR.
- Second redirect while kill=1: pc updates to the newest target; kill stays 1.
- Flushed instructions are never presented (if_valid_o never asserts for a killed response).
- Latency: with gnt in the first ADDR cycle and rvalid one cycle later, an instruction is presented 2 cycles after entering ADDR. Peak rate is 1 instruction per 3 cycles.
- rvalid outside DATA is ignored. Assertion: it must not occur.

Test Plan:
- Reset then release; memory grants immediately and returns rdata=0x00000413 one cycle later -> imem_addr_o=0x80000000; 3 cycles after release if_valid_o=1, if_pc_o=0x80000000, if_dnpc_o=0x80000004, if_inst_o=0x00000413.
- Sequential fetch, no stalls -> addresses 0x80000000, 0x80000004, 0x80000008; stallreq_if_o high in ADDR/DATA, low in DONE.
- Hold in DONE with stall_i[0]=1 for 4 cycles -> outputs stable, imem_req_o=0; release -> next req at pc+4.
- Redirect to 0x80000103 during DATA, then the stale rvalid returns 0xDEADBEEF -> data dropped, if_valid_o stays 0, next req at 0x80000100.
- gnt held low for 5 cycles in ADDR, redirect to 0x80000200 in cycle 2 -> imem_addr_o switches to 0x80000200, kill stays 0, first presented pc=0x80000200.
- rst asserted mid-DATA -> next cycle state IDLE, all outputs 0, then fetch resumes at 0x80000000; pc=0xFFFF_FFFF_FFFF_FFFC advance -> next req addr 0.
